// File: rtl/pl_pkg.sv
// -----------------------------------------------------------------------------
// pl_pkg
// Shared definitions for the pipeline stage registers (D2E, E2M, M2W).
//   - stage_state_e : occupancy state of a stage register (empty / one / two)
//   - DATA_W_DE, CTRL_W_DE : default widths for the decode/execute stage
//   - de_ctrl_t, em_ctrl_t, mw_ctrl_t : per-stage control bundles. Callers
//     pack these into the generic in_ctrl vector of pl_stage_reg.
// -----------------------------------------------------------------------------
package pl_pkg;

    // Occupancy of a stage: no entry, head only, head plus skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // Default widths for the decode/execute instance.
    localparam int DATA_W_DE = 64;
    localparam int CTRL_W_DE = 8;

    // Decode -> execute control bundle.
    typedef struct packed {
        logic       regwe;
        logic       memwe;
        logic       memre;
        logic       is_jump;
        logic       is_branch;
        logic [2:0] alu_op;
    } de_ctrl_t;

    // Execute -> memory control bundle.
    typedef struct packed {
        logic       regwe;
        logic       memwe;
        logic       memre;
        logic [1:0] mem_size;
        logic       mem_signed;
        logic [1:0] wb_sel;
    } em_ctrl_t;

    // Memory -> writeback control bundle.
    typedef struct packed {
        logic       regwe;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } mw_ctrl_t;

    // Helpers that flatten a control bundle into the generic ctrl vector.
    function automatic logic [CTRL_W_DE-1:0] de_ctrl_pack(input de_ctrl_t c);
        return CTRL_W_DE'(c);
    endfunction

    function automatic logic [CTRL_W_DE-1:0] em_ctrl_pack(input em_ctrl_t c);
        return CTRL_W_DE'(c);
    endfunction

    function automatic logic [CTRL_W_DE-1:0] mw_ctrl_pack(input mw_ctrl_t c);
        return CTRL_W_DE'(c);
    endfunction

endpackage

// File: rtl/pl_stall_cnt.sv
// -----------------------------------------------------------------------------
// pl_stall_cnt
// Saturating event counter with synchronous clear, used by every pipeline
// stage to count stall cycles for performance tracking.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset, counter -> 0
//   clr_i   : synchronous clear, wins over inc_i
//   inc_i   : count one event this cycle
//   cnt_o   : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module pl_stall_cnt
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pl_stage_reg.sv
// -----------------------------------------------------------------------------
// pl_stage_reg
// Generic valid/ready pipeline stage register with optional 2-entry skid
// buffer, flush of in-flight control, and a saturating stall counter.
//   clk_in    : clock, rising edge
//   rst_n_in  : asynchronous active-low reset
//   flush     : drop all held entries and the entry offered this cycle
//   in_valid  : upstream entry valid
//   in_ready  : stage accepts an entry this cycle
//   in_data   : upstream payload (DATA_W)
//   in_ctrl   : upstream control bits (CTRL_W)
//   out_valid : head entry valid
//   out_ready : downstream accepts head (low = stall)
//   out_data  : head payload
//   out_ctrl  : head control bits, 0 whenever out_valid is low
//   stat_clr  : synchronous clear of stall_cnt
//   stall_cnt : saturating count of stall cycles (CNT_W)
// SKID=1 : main register M plus skid register S, in_ready straight from a flop.
// SKID=0 : main register M only, in_ready = !out_valid | out_ready.
// -----------------------------------------------------------------------------
module pl_stage_reg
    import pl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DE,
    parameter int CTRL_W = CTRL_W_DE,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic [DATA_W-1:0] m_data_q;
    logic [DATA_W-1:0] m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q;
    logic [CTRL_W-1:0] m_ctrl_d;
    logic [DATA_W-1:0] s_data_q;
    logic [DATA_W-1:0] s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q;
    logic [CTRL_W-1:0] s_ctrl_d;
    logic              in_fire;
    logic              out_fire;
    logic              stall;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State and datapath registers. Reset empties the stage at once, so
    // out_valid drops in the same cycle reset asserts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
        end
    end

    // Next-state logic. Flush wins over everything: control fields are
    // killed but payload is left alone, since only ctrl has side effects
    // downstream and keeping data avoids toggling the wide registers.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = '0;
            s_ctrl_d = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (out_fire) begin
                        if (in_fire) begin
                            m_data_d = in_data;
                            m_ctrl_d = in_ctrl;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else if (in_fire && (SKID != 0)) begin
                        // Head is stalled but in_ready was already high:
                        // park the entry in the skid register.
                        s_data_d = in_data;
                        s_ctrl_d = in_ctrl;
                        state_d  = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        state_d  = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Output logic. out_ctrl is gated so a stale control word never leaks
    // out once the stage has emptied.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_data  = m_data_q;
        out_ctrl  = out_valid ? m_ctrl_q : '0;
    end

    // in_ready generation depends on the buffering mode.
    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Registered ready: high unless the next state holds two
            // entries. Breaks the out_ready -> in_ready timing path.
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_TWO);
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    // A stall is a held head entry that downstream refuses, unless the
    // entry is being flushed anyway.
    assign stall = out_valid & ~out_ready & ~flush;

    pl_stall_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (clk_in),
        .rst_ni (rst_n_in),
        .clr_i  (stat_clr),
        .inc_i  (stall),
        .cnt_o  (stall_cnt)
    );

endmodule

// File: tb/tb_pl_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pl_stage_reg
// Drives one skid instance (SKID=1) and one single-register instance
// (SKID=0) with the same stimulus and compares both against a FIFO model
// of capacity 2 / 1 built from the transfer rules.
// -----------------------------------------------------------------------------
module tb_pl_stage_reg;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int NW = 4;
    localparam int VW = 2 + CW + DW + NW;
    localparam logic [NW-1:0] CNT_MAX = {NW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_ready = 1'b0;
    logic          stat_clr = 1'b0;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_out_ctrl;
    logic [NW-1:0] s_stall;
    logic          n_in_ready, n_out_valid;
    logic [DW-1:0] n_out_data;
    logic [CW-1:0] n_out_ctrl;
    logic [NW-1:0] n_stall;

    int total = 0;
    int bad = 0;

    // Model: per instance a small FIFO (index 0 = skid, 1 = no skid).
    int            mCount[2];
    logic [DW-1:0] mData[2][2];
    logic [CW-1:0] mCtrl[2][2];
    logic [NW-1:0] mStall[2];

    pl_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_skid (
        .clk_in(clk), .rst_n_in(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stat_clr(stat_clr), .stall_cnt(s_stall)
    );

    pl_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_noskid (
        .clk_in(clk), .rst_n_in(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
        .stat_clr(stat_clr), .stall_cnt(n_stall)
    );

    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mCount[i] = 0;
            mStall[i] = '0;
        end
    endtask

    function automatic logic expReady(input int i);
        if (i == 0) return (mCount[0] < 2);
        return (mCount[1] == 0) || out_ready;
    endfunction

    function automatic logic [VW-1:0] expVec(input int i);
        logic v;
        v = (mCount[i] > 0);
        return {expReady(i), v, v ? mCtrl[i][0] : {CW{1'b0}}, v ? mData[i][0] : {DW{1'b0}}, mStall[i]};
    endfunction

    function automatic logic [VW-1:0] dutVec(input int i);
        logic v;
        v = (mCount[i] > 0);
        if (i == 0) return {s_in_ready, s_out_valid, s_out_ctrl, v ? s_out_data : {DW{1'b0}}, s_stall};
        return {n_in_ready, n_out_valid, n_out_ctrl, v ? n_out_data : {DW{1'b0}}, n_stall};
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            logic rdy, vld, inF, outF;
            rdy  = expReady(i);
            vld  = (mCount[i] > 0);
            inF  = in_valid && rdy;
            outF = vld && out_ready;
            if (stat_clr) mStall[i] = '0;
            else if (vld && !out_ready && !flush && (mStall[i] != CNT_MAX)) mStall[i] = mStall[i] + 1'b1;
            if (flush) begin
                mCount[i] = 0;
            end else begin
                if (outF) begin
                    mData[i][0] = mData[i][1];
                    mCtrl[i][0] = mCtrl[i][1];
                    mCount[i]   = mCount[i] - 1;
                end
                if (inF) begin
                    mData[i][mCount[i]] = in_data;
                    mCtrl[i][mCount[i]] = in_ctrl;
                    mCount[i]           = mCount[i] + 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                                 input logic ordy, input logic fl, input logic clr);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        stat_clr  = clr;
    endtask

    // One unchecked flush cycle so the next scenario starts from empty.
    task automatic settle();
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        modelStep();
    endtask

    task automatic test_reset();
        modelReset();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #2;
        total++;
        if ({s_out_valid, s_out_ctrl, s_out_data, s_stall} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_skid got=%h exp=0", {s_out_valid, s_out_ctrl, s_out_data, s_stall});
        end
        total++;
        if ({n_out_valid, n_out_ctrl, n_out_data, n_stall} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_noskid got=%h exp=0", {n_out_valid, n_out_ctrl, n_out_data, n_stall});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({s_in_ready, n_in_ready} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL reset_ready got=%b exp=11", {s_in_ready, n_in_ready});
        end
        modelStep();
    endtask

    task automatic test_stream();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            applyStimulus(k < 4, DW'(16 + k), CW'(k + 1), 1'b1, 1'b0, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dutVec(i) !== expVec(i)) begin
                    bad++;
                    $display("[TB] FAIL stream[%0d] cyc=%0d got=%h exp=%h", i, k, dutVec(i), expVec(i));
                end
            end
            if (k >= 1 && k <= 4) begin
                total++;
                if (s_out_valid !== 1'b1 || s_out_data !== DW'(16 + k - 1) || s_in_ready !== 1'b1 || s_stall !== '0) begin
                    bad++;
                    $display("[TB] FAIL stream_latency cyc=%0d got v=%b d=%h r=%b s=%0d exp v=1 d=%h r=1 s=0",
                             k, s_out_valid, s_out_data, s_in_ready, s_stall, DW'(16 + k - 1));
                end
            end
            modelStep();
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vals[3];
        logic [DW-1:0] got[$];
        int idx;
        int cyc;
        vals[0] = 16'h00A0;
        vals[1] = 16'h00A1;
        vals[2] = 16'h00A2;
        idx = 0;
        cyc = 0;
        settle();
        stat_clr = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        modelStep();
        while ((got.size() < 3) && (cyc < 20)) begin
            @(negedge clk);
            applyStimulus(idx < 3, (idx < 3) ? vals[idx] : {DW{1'b0}}, 8'h11, cyc >= 4, 1'b0, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dutVec(i) !== expVec(i)) begin
                    bad++;
                    $display("[TB] FAIL backpressure[%0d] cyc=%0d got=%h exp=%h", i, cyc, dutVec(i), expVec(i));
                end
            end
            if (cyc == 2 || cyc == 3) begin
                total++;
                if (s_in_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL skid_full_ready cyc=%0d got=%b exp=0", cyc, s_in_ready);
                end
            end
            if (s_out_valid === 1'b1 && out_ready) got.push_back(s_out_data);
            if (in_valid && expReady(0)) idx++;
            modelStep();
            cyc++;
        end
        total++;
        if (got.size() != 3) begin
            bad++;
            $display("[TB] FAIL backpressure_count got=%0d exp=3", got.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                total++;
                if (got[j] !== vals[j]) begin
                    bad++;
                    $display("[TB] FAIL backpressure_order[%0d] got=%h exp=%h", j, got[j], vals[j]);
                end
            end
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (s_stall !== 4'd3) begin
            bad++;
            $display("[TB] FAIL backpressure_stalls got=%0d exp=3", s_stall);
        end
        modelStep();
    endtask

    task automatic test_flush();
        settle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (k)
                0: applyStimulus(1'b1, 16'h00C0, 8'hFF, 1'b0, 1'b0, 1'b0);
                1: applyStimulus(1'b1, 16'h00C1, 8'hFF, 1'b0, 1'b0, 1'b0);
                2: applyStimulus(1'b1, 16'h00B0, 8'hFF, 1'b0, 1'b1, 1'b0);
                default: applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
            endcase
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dutVec(i) !== expVec(i)) begin
                    bad++;
                    $display("[TB] FAIL flush[%0d] cyc=%0d got=%h exp=%h", i, k, dutVec(i), expVec(i));
                end
            end
            if (k >= 3) begin
                total++;
                if ({s_out_valid, s_out_ctrl, s_in_ready, n_out_valid, n_out_ctrl, n_in_ready} !== {1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1}) begin
                    bad++;
                    $display("[TB] FAIL flush_empty cyc=%0d got sv=%b sc=%h sr=%b nv=%b nc=%h nr=%b exp v=0 c=00 r=1",
                             k, s_out_valid, s_out_ctrl, s_in_ready, n_out_valid, n_out_ctrl, n_in_ready);
                end
            end
            modelStep();
        end
    endtask

    task automatic test_saturation();
        settle();
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            applyStimulus(k == 0, 16'h0055, 8'h3C, 1'b0, 1'b0, k == 21);
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dutVec(i) !== expVec(i)) begin
                    bad++;
                    $display("[TB] FAIL saturation[%0d] cyc=%0d got=%h exp=%h", i, k, dutVec(i), expVec(i));
                end
            end
            if (k == 21) begin
                total++;
                if (s_stall !== 4'd15 || n_stall !== 4'd15) begin
                    bad++;
                    $display("[TB] FAIL stall_saturate got=%0d/%0d exp=15", s_stall, n_stall);
                end
            end
            if (k == 22) begin
                total++;
                if (s_stall !== 4'd0 || n_stall !== 4'd0) begin
                    bad++;
                    $display("[TB] FAIL stall_clear got=%0d/%0d exp=0", s_stall, n_stall);
                end
            end
            modelStep();
        end
    endtask

    task automatic test_async_reset();
        settle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, DW'(16'h00D0 + k), 8'h81, 1'b0, 1'b0, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dutVec(i) !== expVec(i)) begin
                    bad++;
                    $display("[TB] FAIL prereset[%0d] cyc=%0d got=%h exp=%h", i, k, dutVec(i), expVec(i));
                end
            end
            modelStep();
        end
        @(negedge clk);
        applyStimulus(1'b1, 16'h00D2, 8'h81, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({s_out_valid, s_out_ctrl, s_stall, n_out_valid, n_out_ctrl, n_stall} !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset got sv=%b sc=%h ss=%0d nv=%b nc=%h ns=%0d exp all 0",
                     s_out_valid, s_out_ctrl, s_stall, n_out_valid, n_out_ctrl, n_stall);
        end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            applyStimulus(k == 0, 16'h00E0, 8'h05, 1'b1, 1'b0, 1'b0);
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dutVec(i) !== expVec(i)) begin
                    bad++;
                    $display("[TB] FAIL postreset[%0d] cyc=%0d got=%h exp=%h", i, k, dutVec(i), expVec(i));
                end
            end
            if (k == 1) begin
                total++;
                if (s_out_valid !== 1'b1 || s_out_data !== 16'h00E0 || s_out_ctrl !== 8'h05) begin
                    bad++;
                    $display("[TB] FAIL postreset_first got v=%b d=%h c=%h exp v=1 d=00e0 c=05",
                             s_out_valid, s_out_data, s_out_ctrl);
                end
            end
            modelStep();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 9) < 7, DW'($urandom), CW'($urandom),
                          $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 31) == 0);
            #1;
            for (int i = 0; i < 2; i++) begin
                total++;
                if (dutVec(i) !== expVec(i)) begin
                    bad++;
                    $display("[TB] FAIL random[%0d] cyc=%0d got=%h exp=%h", i, k, dutVec(i), expVec(i));
                end
            end
            modelStep();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
